// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: a data cache and an instruction cache share one main-memory port.
// Optional starvation guard for the instruction cache is enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 17,
    parameter int LEN          = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  d_req,
    input  logic [1:0]            d_vis_signal,
    input  logic [ADDR_WIDTH-1:0] d_vis_addr,
    input  logic [LEN-1:0]        d_writen_data,
    output logic [1:0]            d_mem_status,
    input  logic                  i_req,
    input  logic [1:0]            i_vis_signal,
    input  logic [ADDR_WIDTH-1:0] i_vis_addr,
    output logic [1:0]            i_mem_status,
    output logic [1:0]            mem_vis_signal,
    output logic [ADDR_WIDTH-1:0] mem_vis_addr,
    output logic [LEN-1:0]        mem_writen_data,
    input  logic [1:0]            mem_status,
    output logic [1:0]            owner,
    output logic                  illegal_op
);

    localparam logic [1:0] MEM_NOP        = 2'd0;
    localparam logic [1:0] MEM_WRITE      = 2'd2;
    localparam logic [1:0] MEM_READ_BURST = 2'd3;
    localparam logic [1:0] MEM_RESTING    = 2'd0;
    localparam logic [1:0] MEM_WORKING    = 2'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_OWN = 2'd1,
        I_OWN = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   illegal_nx;
    logic   starve;
    logic   i_bad_cmd;

    assign i_bad_cmd = (i_vis_signal == MEM_WRITE) || (i_vis_signal == MEM_READ_BURST);

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign starve = (starve_cnt == CNT_W'(STARVE_LIMIT)) && d_req && i_req;

    // Counts data-cache grants that bypassed a waiting instruction cache.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (state_nx == D_OWN && i_req && starve_cnt != CNT_W'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;
            else if (state_nx == I_OWN)
                starve_cnt <= '0;
        end
    end
`else
    logic unused_limit;
    assign unused_limit = (STARVE_LIMIT != 0);
    assign starve = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            illegal_op <= 1'b0;
        end else begin
            state      <= state_nx;
            illegal_op <= illegal_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        illegal_nx = illegal_op;
        case (state)
            IDLE: begin
                if (d_req && !starve)
                    state_nx = D_OWN;
                else if (i_req)
                    state_nx = I_OWN;
            end
            D_OWN: begin
                if (!d_req && mem_status == MEM_RESTING)
                    state_nx = IDLE;
            end
            I_OWN: begin
                if (i_bad_cmd)
                    illegal_nx = 1'b1;
                if (!i_req && mem_status == MEM_RESTING)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_vis_signal  = MEM_NOP;
        mem_vis_addr    = '0;
        mem_writen_data = '0;
        d_mem_status    = MEM_WORKING;
        i_mem_status    = MEM_WORKING;
        case (state)
            D_OWN: begin
                mem_vis_signal  = d_vis_signal;
                mem_vis_addr    = d_vis_addr;
                mem_writen_data = d_writen_data;
                d_mem_status    = mem_status;
            end
            I_OWN: begin
                mem_vis_signal = i_bad_cmd ? MEM_NOP : i_vis_signal;
                mem_vis_addr   = i_vis_addr;
                i_mem_status   = mem_status;
            end
            default: ;
        endcase
    end

    assign owner = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a behavioural ownership model.
// Compile with ARB_STARVE_GUARD_EN defined to exercise the starvation guard expectations.
module tb_mem_arbiter;

    localparam int AW    = 17;
    localparam int LW    = 32;
    localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          d_req, i_req;
    logic [1:0]    d_vis_signal, i_vis_signal;
    logic [AW-1:0] d_vis_addr, i_vis_addr;
    logic [LW-1:0] d_writen_data;
    logic [1:0]    d_mem_status, i_mem_status;
    logic [1:0]    mem_vis_signal;
    logic [AW-1:0] mem_vis_addr;
    logic [LW-1:0] mem_writen_data;
    logic [1:0]    mem_status;
    logic [1:0]    owner;
    logic          illegal_op;

    int total = 0;
    int bad   = 0;

    // reference model: who owns the port, sticky error, and grants given to D while I waited
    int m_owner  = 0;
    bit m_ill    = 0;
    int m_streak = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .LEN(LW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_req(d_req), .d_vis_signal(d_vis_signal), .d_vis_addr(d_vis_addr),
        .d_writen_data(d_writen_data), .d_mem_status(d_mem_status),
        .i_req(i_req), .i_vis_signal(i_vis_signal), .i_vis_addr(i_vis_addr),
        .i_mem_status(i_mem_status),
        .mem_vis_signal(mem_vis_signal), .mem_vis_addr(mem_vis_addr),
        .mem_writen_data(mem_writen_data), .mem_status(mem_status),
        .owner(owner), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit d, input bit i,
                        input logic [1:0] dsig, input logic [AW-1:0] daddr,
                        input logic [LW-1:0] ddata, input logic [1:0] isig,
                        input logic [AW-1:0] iaddr, input logic [1:0] ms);
        logic [1:0]    e_sig, e_dst, e_ist;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_data;
        bit            i_bad;
        @(negedge clk);
        rst_n = rst; d_req = d; i_req = i;
        d_vis_signal = dsig; d_vis_addr = daddr; d_writen_data = ddata;
        i_vis_signal = isig; i_vis_addr = iaddr; mem_status = ms;
        i_bad = (isig == 2'd2) || (isig == 2'd3);
        e_sig = 2'd0; e_addr = '0; e_data = '0; e_dst = 2'd1; e_ist = 2'd1;
        if (m_owner == 1) begin
            e_sig = dsig; e_addr = daddr; e_data = ddata; e_dst = ms;
        end else if (m_owner == 2) begin
            e_sig = i_bad ? 2'd0 : isig; e_addr = iaddr; e_ist = ms;
        end
        #1;
        chk("mem_sig", mem_vis_signal, e_sig);
        chk("mem_addr", mem_vis_addr, e_addr);
        chk("mem_wdata", mem_writen_data, e_data);
        chk("d_status", d_mem_status, e_dst);
        chk("i_status", i_mem_status, e_ist);
        chk("owner", owner, m_owner);
        chk("illegal", illegal_op, m_ill);
        @(posedge clk);
        if (!rst) begin
            m_owner = 0; m_ill = 0; m_streak = 0;
        end else if (m_owner == 0) begin
            if (d && !(GUARD && m_streak == LIMIT && i)) begin
                m_owner = 1;
                if (i && m_streak < LIMIT) m_streak++;
            end else if (i) begin
                m_owner = 2; m_streak = 0;
            end
        end else if (m_owner == 1) begin
            if (!d && ms == 2'd0) m_owner = 0;
        end else begin
            if (i_bad) m_ill = 1;
            if (!i && ms == 2'd0) m_owner = 0;
        end
    endtask

    task automatic idle_step(input bit rst, input bit d, input bit i, input logic [1:0] ms);
        step(rst, d, i, 2'd1, 17'h0AA, 32'hDEAD_BEEF, 2'd1, 17'h055, ms);
    endtask

    initial begin
        rst_n = 1'b0; d_req = 0; i_req = 0; d_vis_signal = 0; i_vis_signal = 0;
        d_vis_addr = 0; i_vis_addr = 0; d_writen_data = 0; mem_status = 0;
        repeat (2) @(posedge clk);

        // reset held, then quiet
        idle_step(0, 0, 0, 2'd1);
        idle_step(0, 0, 0, 2'd1);
        idle_step(1, 0, 0, 2'd1);
        #1 chk("rst_owner", owner, 0);
        chk("rst_sig", mem_vis_signal, 0);
        chk("rst_dst", d_mem_status, 1);
        chk("rst_ist", i_mem_status, 1);

        // simultaneous request goes to data cache
        idle_step(1, 1, 1, 2'd1);
        #1 chk("both_owner", owner, 1);

        // burst passthrough while memory alternates working/resting
        for (int k = 0; k < 8; k++)
            step(1, 1, 1, 2'd3, 17'h100, 32'h1000 + k, 2'd1, 17'h055, (k % 2 == 0) ? 2'd1 : 2'd0);
        step(1, 0, 1, 2'd3, 17'h100, 32'h0, 2'd1, 17'h055, 2'd1);
        #1 chk("hold_working", owner, 1);
        step(1, 0, 1, 2'd3, 17'h100, 32'h0, 2'd1, 17'h055, 2'd0);
        #1 chk("release", owner, 0);
        idle_step(1, 0, 1, 2'd1);
        #1 chk("i_grant", owner, 2);
        idle_step(1, 0, 0, 2'd0);

        // reset during a data write
        idle_step(1, 1, 0, 2'd1);
        step(1, 1, 0, 2'd2, 17'h1F0F0, 32'hCAFE_F00D, 2'd0, 17'h0, 2'd1);
        step(0, 1, 0, 2'd2, 17'h1F0F0, 32'hCAFE_F00D, 2'd0, 17'h0, 2'd1);
        #1 chk("midrst_owner", owner, 0);
        chk("midrst_sig", mem_vis_signal, 0);

        // illegal instruction-cache command
        idle_step(1, 0, 1, 2'd1);
        step(1, 0, 1, 2'd0, 17'h0, 32'h0, 2'd2, 17'h0777, 2'd1);
        #1 chk("ill_set", illegal_op, 1);
        step(1, 0, 1, 2'd0, 17'h0, 32'h0, 2'd1, 17'h0777, 2'd0);
        step(1, 0, 0, 2'd0, 17'h0, 32'h0, 2'd1, 17'h0777, 2'd0);
        idle_step(1, 0, 0, 2'd0);
        #1 chk("ill_held", illegal_op, 1);
        idle_step(0, 0, 0, 2'd0);
        #1 chk("ill_clear", illegal_op, 0);

        // starvation: I always requesting, D reasserted in each idle slot
        for (int r = 0; r <= LIMIT; r++) begin
            idle_step(1, 1, 1, 2'd1);
            #1 chk("starve_grant", owner, (GUARD && r == LIMIT) ? 2 : 1);
            idle_step(1, 0, (owner == 2'd1), 2'd0);
        end

        // randomized traffic
        for (int n = 0; n < 2000; n++)
            step(($urandom_range(63) != 0), ($urandom_range(9) < 6), ($urandom_range(9) < 6),
                 2'($urandom), 17'($urandom), $urandom, 2'($urandom), 17'($urandom),
                 2'($urandom_range(1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
